aftab_csr_access_checker: RTL and testbench

//   Parametrised CSR access checker for the AFTAB interrupt/CSR datapath. Accepts one CSR access

---
 rtl/aftab_csr_access_checker_pkg.sv | 39 +++
 rtl/aftab_csr_access_checker_if.sv | 33 +++
 rtl/aftab_csr_access_checker_addr_match.sv | 20 ++
 rtl/aftab_csr_access_checker.sv | 173 +++++++++++++++++
 tb/tb_aftab_csr_access_checker.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aftab_csr_access_checker_pkg.sv
// Shared types, CSR address-field positions and the default CSR table for the AFTAB CSR access checker.
package aftab_csr_pkg;

  localparam int unsigned CSR_W = 12;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam int unsigned CSR_RO_MSB   = 11;
  localparam int unsigned CSR_RO_LSB   = 10;
  localparam int unsigned CSR_PRIV_MSB = 9;
  localparam int unsigned CSR_PRIV_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_NUM_CSR = 19;

  // Entry 0 (h003) sits in the least significant 12 bits, entry 18 (h300) in the most significant.
  localparam logic [DEFAULT_NUM_CSR*CSR_W-1:0] DEFAULT_CSR_LIST = {
    12'h300, 12'h302, 12'h303, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h000,
    12'h004, 12'h005, 12'h041, 12'h042, 12'h043, 12'h044, 12'h001, 12'h002, 12'h003
  };

  // Write to an address whose top field is 2'b11 targets a read-only CSR.
  function automatic logic ro_viol(input logic [CSR_W-1:0] addr, input logic we);
    return we & (addr[CSR_RO_MSB:CSR_RO_LSB] == 2'b11);
  endfunction

  // Current privilege is below the minimum privilege encoded in the address.
  function automatic logic priv_viol(input logic [CSR_W-1:0] addr, input logic [1:0] priv);
    return priv < addr[CSR_PRIV_MSB:CSR_PRIV_LSB];
  endfunction

endpackage

// File: rtl/aftab_csr_access_checker_if.sv
// Request/response/fault-bookkeeping bundle between the CSR requester and the access checker.
interface aftab_csr_access_checker_if #(
  parameter int unsigned CNT_W = 8
);

  logic                            reqValid;
  logic                            reqReady;
  logic [aftab_csr_pkg::CSR_W-1:0] CSR_AddrIn;
  logic                            writeIntent;
  logic [1:0]                      privLevel;
  logic                            respValid;
  logic                            respReady;
  logic                            nonExistingCSR;
  logic                            readOnlyViol;
  logic                            privViol;
  logic                            illegalAccess;
  logic [aftab_csr_pkg::CSR_W-1:0] faultAddr;
  logic [CNT_W-1:0]                faultCount;
  logic                            clrFault;

  modport master (
    output reqValid, CSR_AddrIn, writeIntent, privLevel, respReady, clrFault,
    input  reqReady, respValid, nonExistingCSR, readOnlyViol, privViol, illegalAccess,
           faultAddr, faultCount
  );

  modport slave (
    input  reqValid, CSR_AddrIn, writeIntent, privLevel, respReady, clrFault,
    output reqReady, respValid, nonExistingCSR, readOnlyViol, privViol, illegalAccess,
           faultAddr, faultCount
  );

endinterface

// File: rtl/aftab_csr_access_checker_addr_match.sv
// Combinational hit detection of one address against every entry of the CSR table.
module aftab_csr_addr_match
  import aftab_csr_pkg::*;
#(
  parameter int unsigned                 NUM_CSR  = DEFAULT_NUM_CSR,
  parameter logic [NUM_CSR*CSR_W-1:0]    CSR_LIST = DEFAULT_CSR_LIST
) (
  input  logic [CSR_W-1:0] i_addr,
  output logic             o_hit_c
);

  // OR of all per-entry equality compares.
  always_comb begin
    o_hit_c = 1'b0;
    for (int i = 0; i < NUM_CSR; i++) begin
      if (CSR_LIST[i*CSR_W +: CSR_W] == i_addr) o_hit_c = 1'b1;
    end
  end

endmodule

// File: rtl/aftab_csr_access_checker.sv
// CSR access checker: validates one CSR access per handshake and keeps first-fault/fault-count state.
module aftab_csr_access_checker
  import aftab_csr_pkg::*;
#(
  parameter int unsigned              NUM_CSR   = DEFAULT_NUM_CSR,
  parameter logic [NUM_CSR*CSR_W-1:0] CSR_LIST  = DEFAULT_CSR_LIST,
  parameter int unsigned              SCAN_MODE = 0,
  parameter int unsigned              CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  aftab_csr_access_checker_if.slave   bus
);

  localparam int unsigned IDX_W = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;

  state_e             r_state, w_next_state;
  logic [IDX_W-1:0]   r_idx, w_next_idx;
  logic [CSR_W-1:0]   r_addr;
  logic               r_we;
  logic [1:0]         r_priv;

  logic               r_req_ready, r_resp_valid;
  logic               r_nonexist, r_ro_viol, r_priv_viol, r_illegal;
  logic [CSR_W-1:0]   r_fault_addr, w_fault_addr;
  logic [CNT_W-1:0]   r_fault_cnt, w_fault_cnt;
  logic               r_sticky, w_sticky;

  logic               w_accept, w_consume, w_hit, w_last, w_enter_resp;
  logic [CSR_W-1:0]   w_src_addr;
  logic               w_src_we;
  logic [1:0]         w_src_priv;
  logic               w_ro, w_pv;

  assign w_accept     = bus.reqValid & r_req_ready;
  assign w_consume    = r_resp_valid & bus.respReady;
  assign w_last       = (r_idx == IDX_W'(NUM_CSR - 1));
  assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);

  // Flags come from the live request when responding straight from IDLE, else from the capture.
  assign w_src_addr = (r_state == IDLE) ? bus.CSR_AddrIn  : r_addr;
  assign w_src_we   = (r_state == IDLE) ? bus.writeIntent : r_we;
  assign w_src_priv = (r_state == IDLE) ? bus.privLevel   : r_priv;
  assign w_ro       = ro_viol(w_src_addr, w_src_we);
  assign w_pv       = priv_viol(w_src_addr, w_src_priv);

  if (SCAN_MODE == 0) begin : g_par
    aftab_csr_addr_match #(
      .NUM_CSR  (NUM_CSR),
      .CSR_LIST (CSR_LIST)
    ) u_match (
      .i_addr  (bus.CSR_AddrIn),
      .o_hit_c (w_hit)
    );
  end else begin : g_seq
    logic [CSR_W-1:0] w_entry;

    // Select the table entry under the scan index.
    always_comb begin
      w_entry = '0;
      for (int i = 0; i < NUM_CSR; i++) begin
        if (r_idx == IDX_W'(i)) w_entry = CSR_LIST[i*CSR_W +: CSR_W];
      end
    end

    assign w_hit = (w_entry == r_addr);
  end

  // Next-state and scan-index logic.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (SCAN_MODE != 0) ? SCAN : RESP;
          w_next_idx   = '0;
        end
      end
      SCAN: begin
        if (w_hit || w_last) w_next_state = RESP;
        else                 w_next_idx   = r_idx + IDX_W'(1);
      end
      RESP: begin
        if (w_consume) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_idx        <= w_next_idx;
      r_req_ready  <= (w_next_state == IDLE);
      r_resp_valid <= (w_next_state == RESP);
    end
  end

  // Capture the accepted request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_we   <= 1'b0;
      r_priv <= 2'd0;
    end else if (w_accept) begin
      r_addr <= bus.CSR_AddrIn;
      r_we   <= bus.writeIntent;
      r_priv <= bus.privLevel;
    end
  end

  // Fault flags load once on entry to RESP and then hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nonexist  <= 1'b0;
      r_ro_viol   <= 1'b0;
      r_priv_viol <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_enter_resp) begin
      r_nonexist  <= ~w_hit;
      r_ro_viol   <= w_ro;
      r_priv_viol <= w_pv;
      r_illegal   <= ~w_hit | w_ro | w_pv;
    end
  end

  // Fault bookkeeping: clear takes effect before recording a simultaneous illegal consume.
  always_comb begin
    w_fault_cnt  = r_fault_cnt;
    w_fault_addr = r_fault_addr;
    w_sticky     = r_sticky;
    if (bus.clrFault) begin
      w_fault_cnt  = '0;
      w_fault_addr = '0;
      w_sticky     = 1'b0;
    end
    if (w_consume && r_illegal) begin
      if (w_fault_cnt != {CNT_W{1'b1}}) w_fault_cnt = w_fault_cnt + CNT_W'(1);
      if (!w_sticky) w_fault_addr = r_addr;
      w_sticky = 1'b1;
    end
  end

  // Fault bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault_cnt  <= '0;
      r_fault_addr <= '0;
      r_sticky     <= 1'b0;
    end else begin
      r_fault_cnt  <= w_fault_cnt;
      r_fault_addr <= w_fault_addr;
      r_sticky     <= w_sticky;
    end
  end

  assign bus.reqReady       = r_req_ready;
  assign bus.respValid      = r_resp_valid;
  assign bus.nonExistingCSR = r_nonexist;
  assign bus.readOnlyViol   = r_ro_viol;
  assign bus.privViol       = r_priv_viol;
  assign bus.illegalAccess  = r_illegal;
  assign bus.faultAddr      = r_fault_addr;
  assign bus.faultCount     = r_fault_cnt;

endmodule

// File: tb/tb_aftab_csr_access_checker.sv
// Directed bench: parallel (dut0), sequential (dut1) and 2-bit counter (dut2) checker instances.
module tb_aftab_csr_access_checker;
  import aftab_csr_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  aftab_csr_access_checker_if #(.CNT_W(8)) bus0 ();
  aftab_csr_access_checker_if #(.CNT_W(8)) bus1 ();
  aftab_csr_access_checker_if #(.CNT_W(2)) bus2 ();

  aftab_csr_access_checker #(.SCAN_MODE(0), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  aftab_csr_access_checker #(.SCAN_MODE(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aftab_csr_access_checker #(.SCAN_MODE(0), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int d, input logic v, input logic [11:0] a, input logic we,
                         input logic [1:0] pl);
    case (d)
      0:       begin bus0.reqValid = v; bus0.CSR_AddrIn = a; bus0.writeIntent = we; bus0.privLevel = pl; end
      1:       begin bus1.reqValid = v; bus1.CSR_AddrIn = a; bus1.writeIntent = we; bus1.privLevel = pl; end
      default: begin bus2.reqValid = v; bus2.CSR_AddrIn = a; bus2.writeIntent = we; bus2.privLevel = pl; end
    endcase
  endtask

  task automatic set_rr_clr(input int d, input logic rr, input logic clr);
    case (d)
      0:       begin bus0.respReady = rr; bus0.clrFault = clr; end
      1:       begin bus1.respReady = rr; bus1.clrFault = clr; end
      default: begin bus2.respReady = rr; bus2.clrFault = clr; end
    endcase
  endtask

  function automatic logic get_rv(input int d);
    case (d)
      0:       return bus0.respValid;
      1:       return bus1.respValid;
      default: return bus2.respValid;
    endcase
  endfunction

  function automatic logic get_rq(input int d);
    case (d)
      0:       return bus0.reqReady;
      1:       return bus1.reqReady;
      default: return bus2.reqReady;
    endcase
  endfunction

  // {nonExistingCSR, readOnlyViol, privViol, illegalAccess}
  function automatic logic [31:0] get_flags(input int d);
    case (d)
      0:       return 32'({bus0.nonExistingCSR, bus0.readOnlyViol, bus0.privViol, bus0.illegalAccess});
      1:       return 32'({bus1.nonExistingCSR, bus1.readOnlyViol, bus1.privViol, bus1.illegalAccess});
      default: return 32'({bus2.nonExistingCSR, bus2.readOnlyViol, bus2.privViol, bus2.illegalAccess});
    endcase
  endfunction

  function automatic logic [31:0] get_faddr(input int d);
    case (d)
      0:       return 32'(bus0.faultAddr);
      1:       return 32'(bus1.faultAddr);
      default: return 32'(bus2.faultAddr);
    endcase
  endfunction

  function automatic logic [31:0] get_fcnt(input int d);
    case (d)
      0:       return 32'(bus0.faultCount);
      1:       return 32'(bus1.faultCount);
      default: return 32'(bus2.faultCount);
    endcase
  endfunction

  // Issue one request from an idle DUT, measure cycles to respValid and check the flags.
  task automatic run_req(input int d, input logic [11:0] a, input logic we, input logic [1:0] pl,
                         input int exp_lat, input logic [31:0] exp_flags, input string tag);
    int lat;
    set_req(d, 1'b1, a, we, pl);
    @(posedge clk); #1;
    set_req(d, 1'b0, a, we, pl);
    @(negedge clk);
    lat = 1;
    while (!get_rv(d) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_flags"}, get_flags(d), exp_flags);
  endtask

  task automatic consume(input int d, input logic clr);
    set_rr_clr(d, 1'b1, clr);
    @(posedge clk); #1;
    set_rr_clr(d, 1'b0, 1'b0);
  endtask

  task automatic clr_only(input int d);
    set_rr_clr(d, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_rr_clr(d, 1'b0, 1'b0);
  endtask

  task automatic check_reset(input int d, input string tag);
    check({tag, "_rq"},    32'(get_rq(d)), 32'd1);
    check({tag, "_rv"},    32'(get_rv(d)), 32'd0);
    check({tag, "_flags"}, get_flags(d),   32'h0);
    check({tag, "_faddr"}, get_faddr(d),   32'h0);
    check({tag, "_fcnt"},  get_fcnt(d),    32'd0);
  endtask

  initial begin
    int seen;
    logic [11:0] ill_addr [4];
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_req(d, 1'b0, 12'h000, 1'b0, PRIV_U);
      set_rr_clr(d, 1'b0, 1'b0);
    end
    repeat (3) @(negedge clk);
    check_reset(0, "rst0");
    check_reset(1, "rst1");
    check_reset(2, "rst2");
    rst = 1'b1;
    @(posedge clk); #1;

    // Parallel mode basics.
    run_req(0, 12'h341, 1'b0, PRIV_M, 1, 32'b0000, "m0_341");
    consume(0, 1'b0);
    check("m0_341_fcnt", get_fcnt(0), 32'd0);
    run_req(0, 12'h300, 1'b0, PRIV_U, 1, 32'b0011, "m0_300u");
    consume(0, 1'b0);
    check("m0_300u_faddr", get_faddr(0), 32'h300);
    check("m0_300u_fcnt",  get_fcnt(0),  32'd1);
    run_req(0, 12'hF11, 1'b1, PRIV_M, 1, 32'b1101, "m0_F11w");
    consume(0, 1'b0);
    check("m0_F11w_faddr", get_faddr(0), 32'h300);
    check("m0_F11w_fcnt",  get_fcnt(0),  32'd2);
    run_req(0, 12'hC00, 1'b0, PRIV_U, 1, 32'b1001, "m0_C00r");
    consume(0, 1'b0);
    run_req(0, 12'hC00, 1'b1, PRIV_U, 1, 32'b1101, "m0_C00w");
    consume(0, 1'b0);
    run_req(0, 12'h344, 1'b0, PRIV_S, 1, 32'b0011, "m0_344s");
    consume(0, 1'b0);
    check("m0_fcnt5", get_fcnt(0), 32'd5);

    // Response held off: outputs frozen, new requests ignored.
    run_req(0, 12'h300, 1'b0, PRIV_U, 1, 32'b0011, "hold");
    set_req(0, 1'b1, 12'h341, 1'b0, PRIV_M);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rv",    32'(get_rv(0)), 32'd1);
      check("hold_flags", get_flags(0),   32'b0011);
      check("hold_rq",    32'(get_rq(0)), 32'd0);
    end
    set_req(0, 1'b0, 12'h341, 1'b0, PRIV_M);
    consume(0, 1'b0);
    check("hold_fcnt",  get_fcnt(0),    32'd6);
    check("hold_faddr", get_faddr(0),   32'h300);
    check("hold_idle",  32'(get_rv(0)), 32'd0);

    // Sequential mode latencies.
    run_req(1, 12'hF11, 1'b1, PRIV_M, 20, 32'b1101, "m1_F11w");
    check("m1_scan_rq", 32'(get_rq(1)), 32'd0);
    consume(1, 1'b0);
    check("m1_F11w_faddr", get_faddr(1), 32'hF11);
    run_req(1, 12'h300, 1'b0, PRIV_M, 20, 32'b0000, "m1_300");
    consume(1, 1'b0);
    run_req(1, 12'h003, 1'b0, PRIV_U, 2, 32'b0000, "m1_003");
    consume(1, 1'b0);
    run_req(1, 12'h341, 1'b0, PRIV_M, 15, 32'b0000, "m1_341");
    consume(1, 1'b0);
    run_req(1, 12'h044, 1'b0, PRIV_U, 5, 32'b0000, "m1_044");
    consume(1, 1'b0);
    check("m1_fcnt1", get_fcnt(1), 32'd1);
    clr_only(1);
    check("m1_clr_fcnt",  get_fcnt(1),  32'd0);
    check("m1_clr_faddr", get_faddr(1), 32'h0);
    run_req(1, 12'h7FF, 1'b0, PRIV_M, 20, 32'b1001, "m1_7FF");
    consume(1, 1'b0);
    run_req(1, 12'h123, 1'b0, PRIV_M, 20, 32'b1001, "m1_123");
    consume(1, 1'b0);
    check("m1_two_faddr", get_faddr(1), 32'h7FF);
    check("m1_two_fcnt",  get_fcnt(1),  32'd2);

    // Saturating 2-bit counter, then clear combined with an illegal consume.
    ill_addr[0] = 12'h7FF;
    ill_addr[1] = 12'h123;
    ill_addr[2] = 12'h456;
    ill_addr[3] = 12'h789;
    for (int i = 0; i < 4; i++) begin
      run_req(2, ill_addr[i], 1'b0, PRIV_M, 1, 32'b1001, "sat");
      consume(2, 1'b0);
      check("sat_fcnt", get_fcnt(2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("sat_faddr", get_faddr(2), 32'h7FF);
    run_req(2, 12'hABC, 1'b0, PRIV_M, 1, 32'b1001, "clrill");
    consume(2, 1'b1);
    check("clrill_fcnt",  get_fcnt(2),  32'd1);
    check("clrill_faddr", get_faddr(2), 32'hABC);

    // Reset in the middle of a scan aborts the request.
    set_req(1, 1'b1, 12'h300, 1'b0, PRIV_M);
    @(posedge clk); #1;
    set_req(1, 1'b0, 12'h300, 1'b0, PRIV_M);
    repeat (5) @(negedge clk);
    check("midscan_rq", 32'(get_rq(1)), 32'd0);
    rst = 1'b0;
    #1;
    check_reset(1, "abort1");
    check_reset(2, "abort2");
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (get_rv(1)) seen++;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    check("abort_rq",      32'(get_rq(1)), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
